// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style serial receiver with mid-bit sampling.
// Reports each frame as a valid pulse or as a frame-error pulse.
module uart_receiver #(
    parameter int CLK_kHZ     = 50000,
    parameter int BITSTREAM   = 9600,
    parameter int DATA_AMOUNT = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   rx_i,
    output logic [DATA_AMOUNT-1:0] data_o,
    output logic                   valid_o,
    output logic                   frame_err_o,
    output logic                   busy_o
);

    localparam int PERIOD = (CLK_kHZ * 1000) / BITSTREAM;
    localparam int HALF   = PERIOD / 2;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IW     = (DATA_AMOUNT > 1) ? $clog2(DATA_AMOUNT) : 1;

    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_AMOUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_AMOUNT-1:0] shreg;

    logic sync1;
    logic rx_s;
    logic rx_d;

    // New bits enter at the MSB so the first bit ends up in bit 0.
    function automatic logic [DATA_AMOUNT-1:0] shift_in(
        input logic [DATA_AMOUNT-1:0] sr,
        input logic                   b
    );
        logic [DATA_AMOUNT:0] t;
        t = {b, sr};
        return t[DATA_AMOUNT:1];
    endfunction

    // Two-flop synchroniser plus one delay stage for start-edge detection.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    // Frame FSM: start validation, data shifting, stop check, break wait.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == PERIOD_M1) begin
                        cnt   <= '0;
                        shreg <= shift_in(shreg, rx_s);
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == PERIOD_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random serial frames against a
// timing-formula model of the receiver, checked every cycle.
module tb_uart_receiver;

    localparam int CLK_KHZ = 2000;
    localparam int BAUD    = 100000;
    localparam int N       = 8;
    localparam int P       = (CLK_KHZ * 1000) / BAUD;
    localparam int H       = P / 2;

    logic         clk  = 1'b0;
    logic         arst = 1'b1;
    logic         rx   = 1'b1;
    logic [N-1:0] data;
    logic         valid;
    logic         ferr;
    logic         busy;

    always #2 clk = ~clk;

    uart_receiver #(
        .CLK_kHZ    (CLK_KHZ),
        .BITSTREAM  (BAUD),
        .DATA_AMOUNT(N)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .rx_i       (rx),
        .data_o     (data),
        .valid_o    (valid),
        .frame_err_o(ferr),
        .busy_o     (busy)
    );

    int tests = 0;
    int fails = 0;

    // model state
    int           edges   = 0;
    bit           started = 1'b0;
    bit           m_f1    = 1'b1;
    bit           m_s     = 1'b1;
    bit           m_d     = 1'b1;
    int           mode    = 0;
    int           t0      = 0;
    int           r;
    int           k;
    logic [N-1:0] word    = '0;
    bit           e_valid = 1'b0;
    bit           e_ferr  = 1'b0;
    bit           e_busy  = 1'b0;
    logic [N-1:0] e_data  = '0;

    // monitor state
    int           nvalid          = 0;
    int           nferr           = 0;
    int           last_valid_edge = 0;
    logic [N-1:0] got[$];
    int           start_edge      = 0;

    // Model: line level as seen after synchronisation, frame timing
    // taken from absolute offsets relative to the start-edge cycle.
    initial forever begin
        @(posedge clk);
        edges++;
        if (arst) begin
            started = 1'b1;
            mode    = 0;
            e_valid = 1'b0;
            e_ferr  = 1'b0;
            e_data  = '0;
            m_f1    = 1'b1;
            m_s     = 1'b1;
            m_d     = 1'b1;
        end else begin
            e_valid = 1'b0;
            e_ferr  = 1'b0;
            case (mode)
                0: begin
                    if (m_d && !m_s) begin
                        mode = 1;
                        t0   = edges;
                    end
                end
                1: begin
                    r = edges - t0;
                    if (r == H) begin
                        if (m_s) mode = 0;
                    end else if (r > H && (r - H) % P == 0) begin
                        k = (r - H) / P - 1;
                        if (k < N) begin
                            word[k] = m_s;
                        end else if (m_s) begin
                            e_valid = 1'b1;
                            e_data  = word;
                            mode    = 0;
                        end else begin
                            e_ferr = 1'b1;
                            mode   = 2;
                        end
                    end
                end
                default: begin
                    if (m_s) mode = 0;
                end
            endcase
            m_d  = m_s;
            m_s  = m_f1;
            m_f1 = rx;
        end
        e_busy = (mode != 0);
    end

    // Compare process: every cycle after the first reset.
    initial forever begin
        @(negedge clk);
        if (started) begin
            tests++;
            if (valid !== e_valid || ferr !== e_ferr ||
                busy !== e_busy || data !== e_data) begin
                fails++;
                $display("FAIL cycle %0d: dut v=%b fe=%b busy=%b d=%h, want v=%b fe=%b busy=%b d=%h",
                         edges, valid, ferr, busy, data,
                         e_valid, e_ferr, e_busy, e_data);
            end
            if (valid === 1'b1) begin
                nvalid++;
                last_valid_edge = edges;
                got.push_back(data);
            end
            if (ferr === 1'b1) nferr++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic mid();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] d, input bit stop, input int per);
        start_edge = edges + 1;
        drive(1'b0, per);
        for (int i = 0; i < N; i++) drive(d[i], per);
        drive(stop, per);
    endtask

    initial begin
        int           nv;
        int           nf;
        int           gq;
        int           kind;
        int           per;
        logic [N-1:0] rd;
        logic [N-1:0] part;

        arst = 1'b1;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        mid();
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_ferr", int'(ferr), 0);
        check("reset_busy", int'(busy), 0);
        arst = 1'b0;
        drive(1'b1, 2 * P);

        nv = nvalid;
        nf = nferr;
        send(8'h72, 1'b1, P);
        drive(1'b1, 3 * P);
        mid();
        check("x72_pulses", nvalid - nv, 1);
        check("x72_data", int'(data), 'h72);
        check("x72_ferr", nferr - nf, 0);
        check("x72_busy", int'(busy), 0);

        nv = nvalid;
        send(8'hA1, 1'b1, P);
        drive(1'b1, 3 * P);
        mid();
        check("xa1_pulses", nvalid - nv, 1);
        check("xa1_data", int'(data), 'hA1);
        check("xa1_valid_edge", last_valid_edge, start_edge + 2 + H + 9 * P);

        nv = nvalid;
        nf = nferr;
        drive(1'b0, 4);
        drive(1'b1, H);
        mid();
        check("glitch_busy", int'(busy), 0);
        drive(1'b1, 2 * P);
        check("glitch_valid", nvalid - nv, 0);
        check("glitch_ferr", nferr - nf, 0);

        nv = nvalid;
        nf = nferr;
        send(8'h55, 1'b0, P);
        drive(1'b0, 200);
        mid();
        check("break_busy", int'(busy), 1);
        drive(1'b0, 200);
        drive(1'b1, 3 * P);
        mid();
        check("ferr_pulses", nferr - nf, 1);
        check("ferr_valid", nvalid - nv, 0);
        check("ferr_data_kept", int'(data), 'hA1);
        check("ferr_busy", int'(busy), 0);
        nv = nvalid;
        send(8'h96, 1'b1, P);
        drive(1'b1, 3 * P);
        mid();
        check("after_ferr_pulses", nvalid - nv, 1);
        check("after_ferr_data", int'(data), 'h96);

        nv = nvalid;
        nf = nferr;
        part = 8'hC3;
        drive(1'b0, P);
        for (int i = 0; i < 3; i++) drive(part[i], P);
        drive(part[3], H);
        arst = 1'b1;
        rx   = 1'b1;
        repeat (2) @(negedge clk);
        mid();
        check("midrst_data", int'(data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ferr", int'(ferr), 0);
        repeat (8) @(negedge clk);
        arst = 1'b0;
        drive(1'b1, 2 * P);
        check("midrst_no_valid", nvalid - nv, 0);
        check("midrst_no_ferr", nferr - nf, 0);
        send(8'h3C, 1'b1, P);
        drive(1'b1, 3 * P);
        mid();
        check("x3c_pulses", nvalid - nv, 1);
        check("x3c_data", int'(data), 'h3C);

        nv = nvalid;
        nf = nferr;
        gq = got.size();
        send(8'h00, 1'b1, P);
        send(8'hFF, 1'b1, P);
        drive(1'b1, 3 * P);
        mid();
        check("b2b_pulses", nvalid - nv, 2);
        check("b2b_ferr", nferr - nf, 0);
        if (got.size() >= gq + 2) begin
            check("b2b_first", int'(got[gq]), 'h00);
            check("b2b_second", int'(got[gq+1]), 'hFF);
        end

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            rd   = N'($urandom);
            if (kind == 0) begin
                drive(1'b0, $urandom_range(1, H - 2));
                drive(1'b1, $urandom_range(H + 2, 2 * P));
            end else if (kind == 1) begin
                send(rd, 1'b0, P);
                drive(1'b0, $urandom_range(0, 3 * P));
                drive(1'b1, $urandom_range(1, P));
            end else begin
                per = P - 1 + $urandom_range(0, 2);
                send(rd, 1'b1, per);
                drive(1'b1, $urandom_range(0, 2 * P));
            end
        end
        drive(1'b1, 3 * P);
        mid();
        check("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
